// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, lane constants and funct3 legality check for the load/store unit
package dmem_pkg;
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    return f3 == 3'b011 || f3[2:1] == 2'b11 || (we && f3[2]);
  endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: load lane extract with sign/zero extension and sub-word store merge
module dmem_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        f3_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ld_o,
  output logic [DATA_W-1:0] st_o
);
  logic [4:0] sh;
  logic [HALF_W-1:0] lane;
  logic [DATA_W-1:0] mask;
  assign sh = {off_i, 3'b000};
  assign lane = HALF_W'(word_i >> sh);
  assign mask = (f3_i[1:0] == 2'b01) ? DATA_W'(HALF_MASK) : DATA_W'(BYTE_MASK);
  assign ld_o = (f3_i == F3_B)  ? {{(DATA_W-BYTE_W){lane[BYTE_W-1]}}, lane[BYTE_W-1:0]} :
                (f3_i == F3_BU) ? DATA_W'(lane[BYTE_W-1:0]) :
                (f3_i == F3_H)  ? {{(DATA_W-HALF_W){lane[HALF_W-1]}}, lane} :
                (f3_i == F3_HU) ? DATA_W'(lane) : word_i;
  assign st_o = (f3_i == F3_W) ? wdata_i : (word_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit with read-modify-write sub-word stores over a byte-enable-less RAM.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned accesses instead of aligning them down.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int RAM_DEPTH    = 1024,
  parameter int ADDR_W       = $clog2(RAM_DEPTH),
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              ram_regce,
  input  logic [DATA_W-1:0] ram_dout
);
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d, off_q, off_d, off_in;
  logic we_q, we_d, rsp_err_q, rsp_err_d, ram_we_q, bad, is_h, is_w, unused_addr;
  logic [2:0] f3_q, f3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, ram_din_q, ram_din_d, rsp_rdata_q, rsp_rdata_d, ld_data, st_data;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  assign is_h = req_funct3[1:0] == 2'b01;
  assign is_w = req_funct3 == F3_W;
  assign off_in = is_w ? 2'b00 : is_h ? {req_addr[1], 1'b0} : req_addr[1:0];
  assign unused_addr = ^req_addr[31:ADDR_W+2];
`ifdef DMEM_MISALIGN_ERR_EN
  assign bad = illegal_f3(req_we, req_funct3) || (is_h && req_addr[0]) || (is_w && req_addr[1:0] != 2'b00);
`else
  assign bad = illegal_f3(req_we, req_funct3);
`endif
  dmem_align #(.DATA_W(DATA_W)) u_align (
    .word_i (ram_dout),
    .off_i  (off_q),
    .f3_i   (f3_q),
    .wdata_i(wdata_q),
    .ld_o   (ld_data),
    .st_o   (st_data)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    f3_d = f3_q;
    off_d = off_q;
    wdata_d = wdata_q;
    ram_addr_d = ram_addr_q;
    ram_din_d = ram_din_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        we_d = req_we;
        f3_d = req_funct3;
        off_d = off_in;
        wdata_d = req_wdata;
        cnt_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d = bad;
        ram_din_d = req_wdata;
        ram_addr_d = bad ? ram_addr_q : req_addr[ADDR_W+1:2];
        state_d = bad ? S_RESP : (req_we && is_w) ? S_WR : S_RD;
      end
      S_RD: if (cnt_q == 2'(READ_LATENCY)) begin
        ram_din_d = st_data;
        rsp_rdata_d = we_q ? '0 : ld_data;
        state_d = we_q ? S_WR : S_RESP;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
      S_WR: state_d = S_RESP;
      S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      wdata_q <= '0;
      ram_addr_q <= '0;
      ram_din_q <= '0;
      ram_we_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      f3_q <= f3_d;
      off_q <= off_d;
      wdata_q <= wdata_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q <= ram_din_d;
      ram_we_q <= state_d == S_WR;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign req_ready = state_q == S_IDLE;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign ram_addr = ram_addr_q;
  assign ram_din = ram_din_q;
  assign ram_we = ram_we_q;
  assign ram_regce = READ_LATENCY == 2;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed checks of two LSU instances (read latency 1 and 2) against a read-first RAM model
module tb_dmem_lsu;
  localparam logic [31:0] W0 = 32'h8081F0F1;
  localparam logic [31:0] W1 = 32'h8081AAF1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_valid, req_we, rsp_ready;
  logic [1:0][2:0] req_funct3;
  logic [1:0][31:0] req_addr, req_wdata, dout1, dout2;
  wire [1:0] req_ready, rsp_valid, rsp_err, ram_we, ram_regce;
  wire [1:0][31:0] rsp_rdata, ram_din, ram_dout;
  wire [1:0][9:0] ram_addr;
  logic [31:0] mem [2][1024];
  int we_cnt [2] = '{0, 0};
  logic [1:0][9:0] we_addr;
  logic [1:0][31:0] we_din;
  int pass_n = 0;
  int total_n = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_lsu #(.READ_LATENCY(g + 1)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_funct3(req_funct3[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
      .ram_addr(ram_addr[g]), .ram_din(ram_din[g]), .ram_we(ram_we[g]), .ram_regce(ram_regce[g]),
      .ram_dout(ram_dout[g])
    );
  end
  assign ram_dout = {dout2[1], dout1[0]};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      dout1[i] <= mem[i][ram_addr[i]];
      if (ram_regce[i]) dout2[i] <= dout1[i];
      if (ram_we[i]) begin
        mem[i][ram_addr[i]] <= ram_din[i];
        we_cnt[i] <= we_cnt[i] + 1;
        we_addr[i] <= ram_addr[i];
        we_din[i] <= ram_din[i];
      end
    end
  end
  task automatic xact(input int k, input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er, output int wes);
    int w0;
    @(negedge clk);
    w0 = we_cnt[k];
    req_valid[k] = 1'b1;
    req_we[k] = we;
    req_funct3[k] = f3;
    req_addr[k] = addr;
    req_wdata[k] = wd;
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[k] && lat < 20);
    rd = rsp_rdata[k];
    er = rsp_err[k];
    @(posedge clk);
    #1 wes = we_cnt[k] - w0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total_n++;
      if (req_ready[k] !== 1'b1) $display("FAIL reset_req_ready k%0d: got %b exp 1", k, req_ready[k]); else pass_n++;
      total_n++;
      if ({rsp_valid[k], rsp_err[k], ram_we[k], ram_addr[k], ram_din[k], rsp_rdata[k]} !== 77'd0)
        $display("FAIL reset_outputs k%0d: got v=%b e=%b we=%b a=%h din=%h rd=%h exp all 0", k, rsp_valid[k],
                 rsp_err[k], ram_we[k], ram_addr[k], ram_din[k], rsp_rdata[k]);
      else pass_n++;
      total_n++;
      if (ram_regce[k] !== (k == 1)) $display("FAIL reset_regce k%0d: got %b exp %0d", k, ram_regce[k], k == 1); else pass_n++;
    end
  endtask
  task automatic test_sw();
    int lat, wes;
    logic [31:0] rd;
    logic er;
    for (int k = 0; k < 2; k++) begin
      xact(k, 1'b1, 3'b010, 32'h10, W0, lat, rd, er, wes);
      total_n++;
      if (lat != 2 || er !== 1'b0 || rd !== 32'h0) $display("FAIL sw_rsp k%0d: got lat=%0d err=%b rd=%h exp 2 0 0", k, lat, er, rd); else pass_n++;
      total_n++;
      if (wes != 1 || we_addr[k] !== 10'd4 || we_din[k] !== W0)
        $display("FAIL sw_write k%0d: got n=%0d a=%h din=%h exp 1 004 %h", k, wes, we_addr[k], we_din[k], W0);
      else pass_n++;
    end
  endtask
  task automatic test_loads();
    logic [2:0] f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ads [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF0F1, 32'h00008081};
    int lat, wes;
    logic [31:0] rd;
    logic er;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        xact(k, 1'b0, f3s[i], ads[i], 32'h0, lat, rd, er, wes);
        total_n++;
        if (lat != k + 3 || rd !== exps[i] || er !== 1'b0 || wes != 0)
          $display("FAIL load%0d k%0d: got lat=%0d rd=%h err=%b wes=%0d exp %0d %h 0 0", i, k, lat, rd, er, wes, k + 3, exps[i]);
        else pass_n++;
      end
    end
  endtask
  task automatic test_sb();
    int lat, wes;
    logic [31:0] rd;
    logic er;
    for (int k = 0; k < 2; k++) begin
      xact(k, 1'b1, 3'b000, 32'h11, 32'h000000AA, lat, rd, er, wes);
      total_n++;
      if (lat != k + 4 || er !== 1'b0 || wes != 1 || we_din[k] !== W1 || we_addr[k] !== 10'd4)
        $display("FAIL sb k%0d: got lat=%0d err=%b n=%0d din=%h a=%h exp %0d 0 1 %h 004", k, lat, er, wes, we_din[k], we_addr[k], k + 4, W1);
      else pass_n++;
      xact(k, 1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, wes);
      total_n++;
      if (lat != k + 3 || rd !== W1 || er !== 1'b0) $display("FAIL sb_lw k%0d: got lat=%0d rd=%h err=%b exp %0d %h 0", k, lat, rd, er, k + 3, W1); else pass_n++;
      xact(k, 1'b0, 3'b000, 32'h11, 32'h0, lat, rd, er, wes);
      total_n++;
      if (rd !== 32'hFFFFFFAA) $display("FAIL sb_lb k%0d: got %h exp ffffffaa", k, rd); else pass_n++;
    end
  endtask
  task automatic test_errors();
    int lat, wes;
    logic [31:0] rd;
    logic er;
    for (int k = 0; k < 2; k++) begin
      xact(k, 1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er, wes);
      total_n++;
      if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || wes != 0) $display("FAIL illegal_ld k%0d: got lat=%0d err=%b rd=%h wes=%0d exp 1 1 0 0", k, lat, er, rd, wes); else pass_n++;
      xact(k, 1'b1, 3'b100, 32'h10, 32'h55, lat, rd, er, wes);
      total_n++;
      if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || wes != 0) $display("FAIL illegal_st k%0d: got lat=%0d err=%b rd=%h wes=%0d exp 1 1 0 0", k, lat, er, rd, wes); else pass_n++;
      xact(k, 1'b0, 3'b010, 32'h12, 32'h0, lat, rd, er, wes);
      total_n++;
`ifdef DMEM_MISALIGN_ERR_EN
      if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || wes != 0) $display("FAIL misalign_lw k%0d: got lat=%0d err=%b rd=%h wes=%0d exp 1 1 0 0", k, lat, er, rd, wes); else pass_n++;
`else
      if (lat != k + 3 || er !== 1'b0 || rd !== W1) $display("FAIL misalign_lw k%0d: got lat=%0d err=%b rd=%h exp %0d 0 %h", k, lat, er, rd, k + 3, W1); else pass_n++;
`endif
      xact(k, 1'b0, 3'b001, 32'h11, 32'h0, lat, rd, er, wes);
      total_n++;
`ifdef DMEM_MISALIGN_ERR_EN
      if (er !== 1'b1 || rd !== 32'h0) $display("FAIL misalign_lh k%0d: got err=%b rd=%h exp 1 0", k, er, rd); else pass_n++;
`else
      if (er !== 1'b0 || rd !== 32'hFFFFAAF1) $display("FAIL misalign_lh k%0d: got err=%b rd=%h exp 0 ffffaaf1", k, er, rd); else pass_n++;
`endif
    end
  endtask
  task automatic test_reset_mid();
    int w0, lat, wes;
    logic [31:0] rd;
    logic er;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      w0 = we_cnt[k];
      req_valid[k] = 1'b1;
      req_we[k] = 1'b1;
      req_funct3[k] = 3'b001;
      req_addr[k] = 32'h10;
      req_wdata[k] = 32'h00001234;
      rsp_ready[k] = 1'b1;
      @(posedge clk);
      #1 req_valid[k] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (6) @(negedge clk);
      total_n++;
      if (we_cnt[k] != w0 || rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1)
        $display("FAIL rst_mid k%0d: got writes=%0d valid=%b ready=%b exp 0 0 1", k, we_cnt[k] - w0, rsp_valid[k], req_ready[k]);
      else pass_n++;
      xact(k, 1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, wes);
      total_n++;
      if (rd !== W1 || er !== 1'b0) $display("FAIL rst_mid_lw k%0d: got rd=%h err=%b exp %h 0", k, rd, er, W1); else pass_n++;
    end
  endtask
  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid[k] = 1'b1;
      req_we[k] = 1'b0;
      req_funct3[k] = 3'b010;
      req_addr[k] = 32'h10;
      rsp_ready[k] = 1'b0;
      @(posedge clk);
      #1 req_valid[k] = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid[k] && n < 20);
      total_n++;
      if (n != k + 3 || rsp_rdata[k] !== W1) $display("FAIL bp_first k%0d: got lat=%0d rd=%h exp %0d %h", k, n, rsp_rdata[k], k + 3, W1); else pass_n++;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        total_n++;
        if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== W1 || req_ready[k] !== 1'b0)
          $display("FAIL bp_hold%0d k%0d: got valid=%b rd=%h ready=%b exp 1 %h 0", c, k, rsp_valid[k], rsp_rdata[k], req_ready[k], W1);
        else pass_n++;
      end
      rsp_ready[k] = 1'b1;
      @(negedge clk);
      total_n++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0) $display("FAIL bp_release k%0d: got ready=%b valid=%b exp 1 0", k, req_ready[k], rsp_valid[k]); else pass_n++;
      req_valid[k] = 1'b1;
      req_funct3[k] = 3'b100;
      req_addr[k] = 32'h13;
      @(posedge clk);
      #1 req_valid[k] = 1'b0;
      total_n++;
      if (req_ready[k] !== 1'b0) $display("FAIL b2b_accept k%0d: got ready=%b exp 0", k, req_ready[k]); else pass_n++;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid[k] && n < 20);
      total_n++;
      if (n != k + 3 || rsp_rdata[k] !== 32'h80) $display("FAIL b2b_rsp k%0d: got lat=%0d rd=%h exp %0d 00000080", k, n, rsp_rdata[k], k + 3); else pass_n++;
      @(posedge clk);
    end
  endtask
  task automatic test_wrap();
    int lat, wes;
    logic [31:0] rd;
    logic er;
    for (int k = 0; k < 2; k++) begin
      xact(k, 1'b0, 3'b010, 32'hFFFF_F010, 32'h0, lat, rd, er, wes);
      total_n++;
      if (rd !== W1 || er !== 1'b0) $display("FAIL wrap k%0d: got rd=%h err=%b exp %h 0", k, rd, er, W1); else pass_n++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    for (int i = 0; i < 2; i++) for (int j = 0; j < 1024; j++) mem[i][j] = 32'h0;
    req_valid = '0;
    req_we = '0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = '1;
    test_reset();
    test_sw();
    test_loads();
    test_sb();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
